aib_avmm_cfg_arbiter: RTL and testbench
=======================================

// Module: aib_avmm_cfg_arbiter
// PURPOSE
//  Shares the single AIB PHY AVMM configuration port among NUM_REQ requesters, e.g. the calibration FSM and a debug/host bridge.
//  Round-robin arbitration at transaction granularity, with optional per-requester lock for multi-access sequences.
//  Routes read responses back to their owner and bounds every read with a timeout.
//  Sits between the requesters and the PHY i_cfg_avmm_* / o_cfg_avmm_* pins.
// PARAMETERS
//  NUM_REQ      2    number of requesters (2..8)
//  ADDR_W       17   AVMM address width
//  DATA_W       32   AVMM data width
//  BE_W         4    byte-enable width (DATA_W/8)
//  RD_TIMEOUT   255  cycles allowed in RDWAIT before synthetic response (>=2)
// PORTS
//  clk              in   1                  config clock; all logic on rising edge
//  rst              in   1                  synchronous, active-high reset
//  req_address      in   NUM_REQ*ADDR_W     per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//  req_read         in   NUM_REQ            per-requester read strobe
//  req_write        in   NUM_REQ            per-requester write strobe
//  req_writedata    in   NUM_REQ*DATA_W     per-requester write data
//  req_byteenable   in   NUM_REQ*BE_W       per-requester byte enables
//  req_lock         in   NUM_REQ            keep grant after current transaction
//  req_waitrequest  out  NUM_REQ            Avalon waitrequest back to each requester
//  req_readdata     out  DATA_W             read data, broadcast to all requesters
//  req_readdatavalid out NUM_REQ            one-hot read-data-valid for the owning requester
//  avmm_address     out  ADDR_W             to PHY
//  avmm_read        out  1                  to PHY
//  avmm_write       out  1                  to PHY
//  avmm_writedata   out  DATA_W             to PHY
//  avmm_byteenable  out  BE_W               to PHY
//  avmm_readdata    in   DATA_W             from PHY
//  avmm_readdatavalid in 1                  from PHY
//  avmm_waitrequest in   1                  from PHY
//  grant            out  NUM_REQ            one-hot current owner; 0 in IDLE
//  err_status       out  3                  sticky flags {proto, stray, timeout}
//  err_clr          in   1                  clears err_status on the next edge
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, grant=0, err_status=0, counter=0, all req_waitrequest=1, req_readdatavalid=0, avmm_read/write=0.
//  Request i active = req_read[i] | req_write[i].
//  IDLE: if any request is active, grant the first active index at or after the pointer, modulo NUM_REQ; next state CMD.
//   Grant takes 1 cycle; no access is issued in the grant cycle.
//  CMD: avmm_* are combinationally muxed from the granted requester.
//   req_waitrequest[g] = avmm_waitrequest; every other bit = 1.
//   The requester must hold its signals stable while waitrequest=1.
//  Accept = granted strobe & ~avmm_waitrequest.
//   Write accepted: the transaction is complete.
//   Read accepted: go to RDWAIT, clear the counter.
//  RDWAIT: avmm_read/write=0; all req_waitrequest=1.
//   On avmm_readdatavalid: req_readdata=avmm_readdata and req_readdatavalid[g]=1 in the same cycle (combinational); the transaction is complete.
//   Counter increments each cycle. On reaching RD_TIMEOUT: req_readdatavalid[g]=1, req_readdata=32'hDEAD_BEEF, set the timeout flag; the transaction is complete.
//  Completion:
//   if req_lock[g]=1, stay in CMD with the same grant (zero-bubble back-to-back);
//   else pointer=g+1 (wrap at NUM_REQ), grant=0, go to IDLE.
//  Granted requester drops its strobe in CMD without being accepted: treated as complete (abandon), set the proto flag.
//  req_read & req_write both set on the granted requester: perform the write, set the proto flag.
//  avmm_readdatavalid outside RDWAIT, including a late response after a timeout or reset: ignored, set the stray flag.
//  err_clr and a new error in the same cycle: the error wins (flag remains 1).
//  rst mid-transaction: immediate return to the reset state. The PHY may still respond; that response is stray.
//  NUM_REQ=1 degenerates to a pass-through with timeout.
// STRUCTURE
//  aib_cfg_pkg:
//   typedef enum logic [1:0] {IDLE, CMD, RDWAIT} cfg_arb_state_t
//   localparam RD_TIMEOUT_DATA = 32'hDEAD_BEEF
//   error-bit index constants
//  Sub-module rr_arbiter #(N): request vector + pointer -> one-hot grant and index; purely combinational.
//  The FSM, counter, muxing and error flags live in the top level.
// TESTING
//  1. Req0 write addr 0x200 data 0x0000_00A5, waitrequest held 3 cycles
//     -> avmm_write high 4 cycles; req_waitrequest[0] low only in the last cycle; req1 sees waitrequest=1 throughout.
//  2. Req0 and req1 both request reads from reset; PHY returns 0x11 then 0x22 with 2-cycle latency
//     -> req0 served first and gets 0x11 on readdatavalid[0]; req1 then gets 0x22 on readdatavalid[1]; pointer ends at 0.
//  3. Req1 with lock=1 issues 3 writes while req0 requests continuously
//     -> three back-to-back avmm writes from req1; req0 granted only after lock drops.
//  4. Read with PHY never responding, RD_TIMEOUT=8
//     -> readdatavalid on the 8th RDWAIT cycle with 0xDEAD_BEEF; err_status=3'b001; err_clr returns it to 0.
//  5. PHY pulses readdatavalid in IDLE
//     -> no req_readdatavalid; err_status=3'b010.
//  6. rst asserted while in RDWAIT, then the PHY responds
//     -> outputs return to reset values; the late response sets only the stray flag.

Source files
------------

// File: rtl/aib_cfg_pkg.sv
// Shared types and constants for the AIB AVMM configuration-port arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package aib_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2
    } cfg_arb_state_t;

    // Data returned to a requester whose read was never answered by the PHY
    localparam logic [31:0] RD_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Bit positions inside err_status = {proto, stray, timeout}
    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_STRAY   = 1;
    localparam int ERR_PROTO   = 2;
    localparam int ERR_W       = 3;

    // Width of a requester index; never zero so a single requester still gets a 1-bit index
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first active request at or after the pointer, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module rr_arbiter
    import aib_cfg_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_j;

    // Scan N positions starting at the pointer; the first hit wins
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = '0;
        for (int k = 0; k < N; k++) begin
            w_j = IW'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_idx      = w_j;
                o_gnt[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aib_avmm_cfg_arbiter.sv
// Shares one PHY AVMM config port among NUM_REQ requesters, round-robin per transaction with optional lock.
// Latency: 1-cycle grant, then combinational pass-through of command and read response.
// Backpressure: PHY waitrequest is forwarded only to the owner; everyone else sees waitrequest=1.
module aib_avmm_cfg_arbiter
    import aib_cfg_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int BE_W       = 4,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic [ADDR_W-1:0]         avmm_address,
    output logic                      avmm_read,
    output logic                      avmm_write,
    output logic [DATA_W-1:0]         avmm_writedata,
    output logic [BE_W-1:0]           avmm_byteenable,
    input  logic [DATA_W-1:0]         avmm_readdata,
    input  logic                      avmm_readdatavalid,
    input  logic                      avmm_waitrequest,
    output logic [NUM_REQ-1:0]        grant,
    output logic [ERR_W-1:0]          err_status,
    input  logic                      err_clr
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = $clog2(RD_TIMEOUT + 1);

    cfg_arb_state_t      r_state, w_state_nxt;
    logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
    logic [IW-1:0]       r_gidx, w_gidx_nxt;
    logic [IW-1:0]       r_ptr, w_ptr_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [ERR_W-1:0]    r_err, w_err_set;

    logic [NUM_REQ-1:0]  w_arb_gnt;
    logic [IW-1:0]       w_arb_idx;
    logic                w_arb_any;
    logic                w_g_rd, w_g_wr, w_g_lock;
    logic                w_timeout, w_done;
    logic [IW-1:0]       w_ptr_inc;

    logic [ADDR_W-1:0]   w_addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   w_wdat_arr [NUM_REQ];
    logic [BE_W-1:0]     w_be_arr   [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi] = req_address[gi*ADDR_W +: ADDR_W];
        assign w_wdat_arr[gi] = req_writedata[gi*DATA_W +: DATA_W];
        assign w_be_arr[gi]   = req_byteenable[gi*BE_W +: BE_W];
    end

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .i_req (req_read | req_write),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // Owner's command fields always drive the PHY bus; only the strobes are gated by state
    assign avmm_address    = w_addr_arr[r_gidx];
    assign avmm_writedata  = w_wdat_arr[r_gidx];
    assign avmm_byteenable = w_be_arr[r_gidx];

    assign w_g_rd    = req_read[r_gidx];
    assign w_g_wr    = req_write[r_gidx];
    assign w_g_lock  = req_lock[r_gidx];
    assign w_timeout = (r_cnt == CW'(RD_TIMEOUT - 1));
    assign w_ptr_inc = (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;

    // Read data is broadcast; only an unanswered read substitutes the marker word
    assign req_readdata = (r_state == RDWAIT && !avmm_readdatavalid && w_timeout)
                          ? DATA_W'(RD_TIMEOUT_DATA) : avmm_readdata;

    assign grant      = r_grant;
    assign err_status = r_err;

    // Next-state, requester/PHY strobes and error detection
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_gidx_nxt        = r_gidx;
        w_ptr_nxt         = r_ptr;
        w_cnt_nxt         = r_cnt;
        w_err_set         = '0;
        w_done            = 1'b0;
        req_waitrequest   = '1;
        req_readdatavalid = '0;
        avmm_read         = 1'b0;
        avmm_write        = 1'b0;

        // A response nobody is waiting for, e.g. after a timeout or reset
        if (avmm_readdatavalid && r_state != RDWAIT) begin
            w_err_set[ERR_STRAY] = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    w_grant_nxt = w_arb_gnt;
                    w_gidx_nxt  = w_arb_idx;
                    w_state_nxt = CMD;
                end
            end
            CMD: begin
                // Read and write together is illegal; the write is the one carried out
                avmm_write              = w_g_wr;
                avmm_read               = w_g_rd & ~w_g_wr;
                req_waitrequest[r_gidx] = avmm_waitrequest;
                if (w_g_rd && w_g_wr) begin
                    w_err_set[ERR_PROTO] = 1'b1;
                end
                if (!(w_g_rd || w_g_wr)) begin
                    // Owner walked away before acceptance: release the port
                    w_err_set[ERR_PROTO] = 1'b1;
                    w_done               = 1'b1;
                end else if (!avmm_waitrequest) begin
                    if (w_g_wr) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_nxt = RDWAIT;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            RDWAIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (avmm_readdatavalid) begin
                    req_readdatavalid = r_grant;
                    w_done            = 1'b1;
                end else if (w_timeout) begin
                    req_readdatavalid      = r_grant;
                    w_err_set[ERR_TIMEOUT] = 1'b1;
                    w_done                 = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase

        // A locked owner keeps the port with no bubble; otherwise rotate past it
        if (w_done) begin
            if (w_g_lock) begin
                w_state_nxt = CMD;
            end else begin
                w_ptr_nxt   = w_ptr_inc;
                w_grant_nxt = '0;
                w_state_nxt = IDLE;
            end
        end
    end

    // FSM, grant, round-robin pointer and read-wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Sticky error flags; a new error in the clear cycle survives the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            r_err <= (err_clr ? '0 : r_err) | w_err_set;
        end
    end

endmodule

// File: tb/tb_aib_avmm_cfg_arbiter.sv
// Self-checking bench: directed corner cases, then random traffic against a transaction-level model.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: PHY waitrequest and read latency are randomised in the random phase.
module tb_aib_avmm_cfg_arbiter;

    localparam int N  = 2;
    localparam int AW = 17;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] req_address;
    logic [N-1:0]    req_read, req_write, req_lock;
    logic [N*DW-1:0] req_writedata;
    logic [N*BW-1:0] req_byteenable;
    logic [N-1:0]    req_waitrequest, req_readdatavalid;
    logic [DW-1:0]   req_readdata;
    logic [AW-1:0]   avmm_address;
    logic            avmm_read, avmm_write;
    logic [DW-1:0]   avmm_writedata;
    logic [BW-1:0]   avmm_byteenable;
    logic [DW-1:0]   avmm_readdata;
    logic            avmm_readdatavalid, avmm_waitrequest;
    logic [N-1:0]    grant;
    logic [2:0]      err_status;
    logic            err_clr;

    aib_avmm_cfg_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .RD_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_address(req_address), .req_read(req_read), .req_write(req_write),
        .req_writedata(req_writedata), .req_byteenable(req_byteenable), .req_lock(req_lock),
        .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
        .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
        .avmm_readdata(avmm_readdata), .avmm_readdatavalid(avmm_readdatavalid),
        .avmm_waitrequest(avmm_waitrequest),
        .grant(grant), .err_status(err_status), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit lk);
        req_read[i]                  = rd;
        req_write[i]                 = wr;
        req_lock[i]                  = lk;
        req_address[i*AW +: AW]      = a;
        req_writedata[i*DW +: DW]    = d;
        req_byteenable[i*BW +: BW]   = 4'hF;
    endtask

    // ---------------- transaction-level reference model ----------------
    int            owner;      // requester holding the port, -1 when free
    int            p;          // next requester to be favoured
    bit            rd_phase;   // owner's read accepted, response outstanding
    logic [N-1:0]  busy, waiting, is_rd;
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_dat  [N];
    logic [BW-1:0] m_be   [N];
    int            phy_lat;
    logic [DW-1:0] phy_dat;
    int            n_done;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] act);
        for (int k = 0; k < N; k++) begin
            if (act[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic finish_txn();
        busy[owner]    = 1'b0;
        waiting[owner] = 1'b0;
        rd_phase       = 1'b0;
        p              = (owner + 1) % N;
        owner          = -1;
        n_done++;
    endtask

    task automatic rnd_cycle(input bit gen);
        logic [N-1:0] act, exp_g, exp_wr;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_read[i]                = busy[i] && !waiting[i] && is_rd[i];
            req_write[i]               = busy[i] && !waiting[i] && !is_rd[i];
            req_lock[i]                = 1'b0;
            req_address[i*AW +: AW]    = m_addr[i];
            req_writedata[i*DW +: DW]  = m_dat[i];
            req_byteenable[i*BW +: BW] = m_be[i];
        end
        avmm_waitrequest   = ($urandom_range(0, 2) == 0);
        avmm_readdatavalid = rd_phase && (phy_lat == 0);
        avmm_readdata      = avmm_readdatavalid ? phy_dat : $urandom;
        #1;
        act   = req_read | req_write;
        exp_g = '0;
        if (owner >= 0) exp_g[owner] = 1'b1;
        exp_wr = '1;
        if (owner >= 0 && !rd_phase) exp_wr[owner] = avmm_waitrequest;
        check_eq("rnd_grant", grant, exp_g);
        check_eq("rnd_waitreq", req_waitrequest, exp_wr);
        if (owner >= 0 && !rd_phase) begin
            check_eq("rnd_avmm_wr", avmm_write, !is_rd[owner]);
            check_eq("rnd_avmm_rd", avmm_read, is_rd[owner]);
            check_eq("rnd_addr", avmm_address, m_addr[owner]);
            if (!is_rd[owner]) begin
                check_eq("rnd_wdata", avmm_writedata, m_dat[owner]);
                check_eq("rnd_be", avmm_byteenable, m_be[owner]);
            end
        end else begin
            check_eq("rnd_no_strobe", {avmm_read, avmm_write}, 2'b00);
        end
        if (owner >= 0 && rd_phase && avmm_readdatavalid) begin
            check_eq("rnd_rdv", req_readdatavalid, exp_g);
            check_eq("rnd_rdata", req_readdata, phy_dat);
        end else begin
            check_eq("rnd_rdv_quiet", req_readdatavalid, '0);
        end
        // advance the model to what the next edge does
        if (owner < 0) begin
            owner = rr_pick(p, act);
        end else if (!rd_phase) begin
            if (act[owner] && !avmm_waitrequest) begin
                if (is_rd[owner]) begin
                    rd_phase       = 1'b1;
                    waiting[owner] = 1'b1;
                    phy_lat        = $urandom_range(0, 4);
                    phy_dat        = $urandom;
                end else begin
                    finish_txn();
                end
            end
        end else if (avmm_readdatavalid) begin
            finish_txn();
        end else begin
            phy_lat--;
        end
        if (gen) begin
            for (int i = 0; i < N; i++) begin
                if (!busy[i] && $urandom_range(0, 2) == 0) begin
                    busy[i]   = 1'b1;
                    is_rd[i]  = 1'($urandom_range(0, 1));
                    m_addr[i] = AW'($urandom);
                    m_dat[i]  = $urandom;
                    m_be[i]   = BW'($urandom);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        bit drain_ok;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; err_clr = 1'b0;
        req_read = '0; req_write = '0; req_lock = '0;
        req_address = '0; req_writedata = '0; req_byteenable = '0;
        avmm_readdata = '0; avmm_readdatavalid = 1'b0; avmm_waitrequest = 1'b0;
        owner = -1; p = 0; rd_phase = 1'b0; busy = '0; waiting = '0; is_rd = '0;
        phy_lat = 0; phy_dat = '0; n_done = 0;
        for (int i = 0; i < N; i++) begin
            m_addr[i] = '0; m_dat[i] = '0; m_be[i] = '0;
        end

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_grant", grant, 2'b00);
        check_eq("rst_waitreq", req_waitrequest, 2'b11);
        check_eq("rst_rdv", req_readdatavalid, 2'b00);
        check_eq("rst_err", err_status, 3'b000);
        check_eq("rst_strobes", {avmm_read, avmm_write}, 2'b00);
        @(negedge clk); rst = 1'b0;

        // write with PHY waitrequest held 3 cycles
        @(negedge clk);
        set_req(0, 1'b0, 1'b1, AW'(32'h200), 32'h0000_00A5, 1'b0);
        avmm_waitrequest = 1'b1;
        #1;
        check_eq("t1_grant_cycle", {grant, avmm_write}, 3'b000);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); avmm_waitrequest = (k < 4); #1;
            check_eq("t1_avmm_write", avmm_write, 1'b1);
            check_eq("t1_waitreq", req_waitrequest, (k < 4) ? 2'b11 : 2'b10);
            check_eq("t1_grant", grant, 2'b01);
        end
        check_eq("t1_addr", avmm_address, AW'(32'h200));
        check_eq("t1_data", avmm_writedata, 32'h0000_00A5);
        @(negedge clk); set_req(0, 1'b0, 1'b0, '0, '0, 1'b0); avmm_waitrequest = 1'b0; #1;
        check_eq("t1_release", {grant, avmm_write}, 3'b000);

        // locked burst of three writes from req1 while req0 waits
        @(negedge clk);
        set_req(0, 1'b0, 1'b1, AW'(32'h10), 32'h1, 1'b0);
        set_req(1, 1'b0, 1'b1, AW'(32'h300), 32'h100, 1'b1);
        #1;
        check_eq("t3_grant_cycle", grant, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_req(1, 1'b0, 1'b1, AW'(32'h300 + k), 32'h100 + k, (k < 2));
            #1;
            check_eq("t3_lock_grant", grant, 2'b10);
            check_eq("t3_addr", avmm_address, AW'(32'h300 + k));
            check_eq("t3_write", avmm_write, 1'b1);
            check_eq("t3_waitreq", req_waitrequest, 2'b01);
        end
        @(negedge clk); set_req(1, 1'b0, 1'b0, '0, '0, 1'b0); #1;
        check_eq("t3_unlock_idle", grant, 2'b00);
        @(negedge clk); #1;
        check_eq("t3_req0_grant", grant, 2'b01);
        check_eq("t3_req0_addr", avmm_address, AW'(32'h10));
        @(negedge clk); set_req(0, 1'b0, 1'b0, '0, '0, 1'b0); #1;
        check_eq("t3_done", grant, 2'b00);

        // read that the PHY never answers
        @(negedge clk); set_req(0, 1'b1, 1'b0, AW'(32'h40), '0, 1'b0); #1;
        check_eq("t4_grant_cycle", grant, 2'b00);
        @(negedge clk); #1;
        check_eq("t4_read", avmm_read, 1'b1);
        check_eq("t4_grant", grant, 2'b01);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k == 1) set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
            avmm_readdata = $urandom;
            #1;
            check_eq("t4_rdv", req_readdatavalid, (k == TO) ? 2'b01 : 2'b00);
            if (k == 1) begin
                check_eq("t4_wait_strobes", {avmm_read, avmm_write}, 2'b00);
                check_eq("t4_wait_waitreq", req_waitrequest, 2'b11);
            end
            if (k == TO) check_eq("t4_marker", req_readdata, 32'hDEAD_BEEF);
        end
        @(negedge clk); #1;
        check_eq("t4_err", err_status, 3'b001);
        check_eq("t4_idle", grant, 2'b00);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; #1;
        check_eq("t4_err_clr", err_status, 3'b000);

        // stray response while idle, and error beating a simultaneous clear
        @(negedge clk); avmm_readdatavalid = 1'b1; #1;
        check_eq("t5_no_rdv", req_readdatavalid, 2'b00);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); avmm_readdatavalid = 1'b0; err_clr = 1'b0; #1;
        check_eq("t5_stray_beats_clr", err_status, 3'b010);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; #1;
        check_eq("t5_err_clr", err_status, 3'b000);

        // reset in the middle of a read, then a late response
        @(negedge clk); set_req(1, 1'b1, 1'b0, AW'(32'h55), '0, 1'b0);
        @(negedge clk); #1;
        check_eq("t6_read", {grant, avmm_read}, 3'b101);
        @(negedge clk); set_req(1, 1'b0, 1'b0, '0, '0, 1'b0); #1;
        check_eq("t6_rdwait", {grant, avmm_read}, 3'b100);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        check_eq("t6_rst_grant", grant, 2'b00);
        check_eq("t6_rst_waitreq", req_waitrequest, 2'b11);
        check_eq("t6_rst_err", err_status, 3'b000);
        @(negedge clk); avmm_readdatavalid = 1'b1; avmm_readdata = 32'h77; #1;
        check_eq("t6_late_rdv", req_readdatavalid, 2'b00);
        @(negedge clk); avmm_readdatavalid = 1'b0; #1;
        check_eq("t6_late_err", err_status, 3'b010);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;

        // random traffic; pointer restarted at 0 by the reset above
        for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
        drain_ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            rnd_cycle(1'b0);
            if (owner < 0 && busy == '0) begin
                drain_ok = 1'b1;
                break;
            end
        end
        check_eq("rnd_drain", drain_ok, 1'b1);
        rnd_cycle(1'b0);
        check_eq("rnd_err", err_status, 3'b000);
        check_eq("rnd_progress", (n_done > 100), 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
